// File: rtl/jt6295_adpcm_pkg.sv
// Shared constants and tables for the 4-voice OKI ADPCM decoder.
// Optional build macro: JT6295_CH_MUTE_EN (per-voice output mute).
package jt6295_pkg;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CH_W     = 2;
  localparam int unsigned SND_W    = 12;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned STEP_W   = 11;
  localparam int unsigned VOL_W    = 6;
  localparam int unsigned IDX_MAX  = 48;

  // Standard OKI step-size table, indexed by step index 0..48
  localparam logic [STEP_W-1:0] STEP_TBL [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  // Step-index adjustment by nibble magnitude
  localparam logic signed [4:0] ADJ [8] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  // Volume multipliers (x/32) by attenuation index
  localparam logic [VOL_W-1:0] VOL_TBL [9] = '{
    6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3, 6'd2
  };

  // Attenuation index to multiplier; indices past the table are silent
  function automatic logic [VOL_W-1:0] vol_of(input logic [3:0] att);
    if (att > 4'd8) return '0;
    return VOL_TBL[att];
  endfunction

endpackage

// File: rtl/jt6295_adpcm_if.sv
// Slot bus between the sequencer (master) and the ADPCM decoder (slave).
// Optional build macro: JT6295_CH_MUTE_EN adds ch_mute.
interface jt6295_adpcm_if;
  import jt6295_pkg::*;

  logic                    cen4;
  logic                    cen;
  logic [CH_W-1:0]         ch;
  logic [3:0]              nibble;
  logic                    valid;
  logic                    restart;
  logic [3:0]              att;
`ifdef JT6295_CH_MUTE_EN
  logic [CHANNELS-1:0]     ch_mute;
`endif
  logic signed [SND_W-1:0] sound_out;
  logic                    sample;

  modport master (
`ifdef JT6295_CH_MUTE_EN
    output ch_mute,
`endif
    output cen4, cen, ch, nibble, valid, restart, att,
    input  sound_out, sample
  );

  modport slave (
`ifdef JT6295_CH_MUTE_EN
    input  ch_mute,
`endif
    input  cen4, cen, ch, nibble, valid, restart, att,
    output sound_out, sample
  );

endinterface

// File: rtl/jt6295_adpcm_step.sv
// Combinational single-nibble ADPCM update of one voice's signal and step index.
module jt6295_adpcm_step
  import jt6295_pkg::*;
(
  input  logic signed [SND_W-1:0] signal,
  input  logic [IDX_W-1:0]        idx,
  input  logic [3:0]              nibble,
  output logic signed [SND_W-1:0] signal_nx,
  output logic [IDX_W-1:0]        idx_nx
);

  localparam logic signed [13:0] SAT_HI = 14'sd2047;
  localparam logic signed [13:0] SAT_LO = -14'sd2048;

  logic [IDX_W-1:0]  idx_c;
  logic [STEP_W-1:0] step;
  logic [12:0]       delta;
  logic signed [13:0] sum;
  logic signed [7:0]  idx_sum;

  // Delta from step size, saturating signal update, clamped index update
  always_comb begin
    idx_c = (idx > IDX_W'(IDX_MAX)) ? IDX_W'(IDX_MAX) : idx;
    step  = STEP_TBL[idx_c];
    delta = 13'(step >> 3);
    if (nibble[0]) delta = delta + 13'(step >> 2);
    if (nibble[1]) delta = delta + 13'(step >> 1);
    if (nibble[2]) delta = delta + 13'(step);
    if (nibble[3]) sum = 14'(signal) - $signed({1'b0, delta});
    else           sum = 14'(signal) + $signed({1'b0, delta});
    if (sum > SAT_HI)      signal_nx = SND_W'(SAT_HI);
    else if (sum < SAT_LO) signal_nx = SND_W'(SAT_LO);
    else                   signal_nx = SND_W'(sum);
    idx_sum = $signed({2'b00, idx_c}) + 8'(ADJ[nibble[2:0]]);
    if (idx_sum < 8'sd0)       idx_nx = '0;
    else if (idx_sum > 8'sd48) idx_nx = IDX_W'(IDX_MAX);
    else                       idx_nx = IDX_W'(idx_sum);
  end

endmodule

// File: rtl/jt6295_adpcm.sv
// Time-multiplexed 4-voice ADPCM decoder: A = capture/read, B = decode/write-back,
// C = attenuate/present. Optional build macro: JT6295_CH_MUTE_EN.
module jt6295_adpcm
  import jt6295_pkg::*;
(
  input logic          clk,
  input logic          rst,
  jt6295_adpcm_if.slave bus
);

  logic signed [SND_W-1:0] sig_mem_q [CHANNELS];
  logic signed [SND_W-1:0] sig_mem_d [CHANNELS];
  logic [IDX_W-1:0]        idx_mem_q [CHANNELS];
  logic [IDX_W-1:0]        idx_mem_d [CHANNELS];

  logic                    a_go_q, a_go_d;
  logic [CH_W-1:0]         a_ch_q, a_ch_d;
  logic [3:0]              a_nib_q, a_nib_d;
  logic [3:0]              a_att_q, a_att_d;
  logic                    a_valid_q, a_valid_d;
  logic                    a_restart_q, a_restart_d;
  logic signed [SND_W-1:0] a_sig_q, a_sig_d;
  logic [IDX_W-1:0]        a_idx_q, a_idx_d;

  logic                    b_go_q, b_go_d;
  logic [3:0]              b_att_q, b_att_d;
  logic signed [SND_W-1:0] b_val_q, b_val_d;

  logic signed [SND_W-1:0] sound_out_q, sound_out_d;
  logic                    sample_q, sample_d;

  logic signed [SND_W-1:0] step_sig;
  logic [IDX_W-1:0]        step_idx;
  logic signed [18:0]      prod;
  logic                    unused_cen;

  assign unused_cen = bus.cen;

  jt6295_adpcm_step u_step (
    .signal    (a_sig_q),
    .idx       (a_idx_q),
    .nibble    (a_nib_q),
    .signal_nx (step_sig),
    .idx_nx    (step_idx)
  );

  // Pipeline next-state: capture on cen4, decode and write back, then scale
  always_comb begin
    sig_mem_d   = sig_mem_q;
    idx_mem_d   = idx_mem_q;
    a_ch_d      = a_ch_q;
    a_nib_d     = a_nib_q;
    a_att_d     = a_att_q;
    a_valid_d   = a_valid_q;
    a_restart_d = a_restart_q;
    a_sig_d     = a_sig_q;
    a_idx_d     = a_idx_q;
    b_att_d     = b_att_q;
    b_val_d     = b_val_q;
    sound_out_d = sound_out_q;
    prod        = '0;
    a_go_d      = bus.cen4;
    b_go_d      = a_go_q;
    sample_d    = b_go_q;

    if (bus.cen4) begin
      a_ch_d      = bus.ch;
      a_nib_d     = bus.nibble;
      a_att_d     = bus.att;
      a_valid_d   = bus.valid;
      a_restart_d = bus.restart;
      a_sig_d     = sig_mem_q[bus.ch];
      a_idx_d     = idx_mem_q[bus.ch];
    end

    if (a_go_q) begin
      b_att_d = a_att_q;
      b_val_d = '0;
      if (a_restart_q) begin
        sig_mem_d[a_ch_q] = '0;
        idx_mem_d[a_ch_q] = '0;
      end else if (a_valid_q) begin
        sig_mem_d[a_ch_q] = step_sig;
        idx_mem_d[a_ch_q] = step_idx;
        b_val_d           = step_sig;
      end
`ifdef JT6295_CH_MUTE_EN
      if (bus.ch_mute[a_ch_q]) b_val_d = '0;
`endif
    end

    if (b_go_q) begin
      prod        = 19'(b_val_q) * 19'($signed({1'b0, vol_of(b_att_q)}));
      sound_out_d = SND_W'(prod >>> 5);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sig_mem_q[i] <= '0;
        idx_mem_q[i] <= '0;
      end
      a_go_q      <= 1'b0;
      a_ch_q      <= '0;
      a_nib_q     <= '0;
      a_att_q     <= '0;
      a_valid_q   <= 1'b0;
      a_restart_q <= 1'b0;
      a_sig_q     <= '0;
      a_idx_q     <= '0;
      b_go_q      <= 1'b0;
      b_att_q     <= '0;
      b_val_q     <= '0;
      sound_out_q <= '0;
      sample_q    <= 1'b0;
    end else begin
      sig_mem_q   <= sig_mem_d;
      idx_mem_q   <= idx_mem_d;
      a_go_q      <= a_go_d;
      a_ch_q      <= a_ch_d;
      a_nib_q     <= a_nib_d;
      a_att_q     <= a_att_d;
      a_valid_q   <= a_valid_d;
      a_restart_q <= a_restart_d;
      a_sig_q     <= a_sig_d;
      a_idx_q     <= a_idx_d;
      b_go_q      <= b_go_d;
      b_att_q     <= b_att_d;
      b_val_q     <= b_val_d;
      sound_out_q <= sound_out_d;
      sample_q    <= sample_d;
    end
  end

  assign bus.sound_out = sound_out_q;
  assign bus.sample    = sample_q;

endmodule
